// File: rtl/idli_sregs_m.sv
// Bit-serial register file for the idli core: registers rotate one slice per
// active cycle, reads expose the LS slice, writes replace a register over one frame.

module idli_sregs_rd_m #(
  parameter int NUM_REGS = 8,
  parameter int IDX_W    = 3,
  parameter int SLICE_W  = 4,
  parameter bit ZERO_R0  = 1'b0
) (
  input  logic [NUM_REGS-1:0][SLICE_W-1:0] i_ls,
  input  logic [IDX_W-1:0]                 i_idx,
  output logic [SLICE_W-1:0]               o_data
);
  logic w_ok;

  assign w_ok   = (32'(i_idx) < 32'(NUM_REGS)) && !(ZERO_R0 && (i_idx == '0));
  assign o_data = w_ok ? i_ls[i_idx] : '0;
endmodule

module idli_sregs_m #(
  parameter int NUM_REGS = 8,
  parameter int REG_W    = 16,
  parameter int SLICE_W  = 4,
  parameter int NUM_RD   = 2,
  parameter bit ZERO_R0  = 1'b0,
  localparam int IDX_W   = $clog2(NUM_REGS),
  localparam int SLICES  = REG_W / SLICE_W,
  localparam int PH_W    = $clog2(SLICES)
) (
  input  logic                             i_reg_gck,
  input  logic                             i_reg_rst,
  input  logic                             i_reg_stall,
  input  logic [NUM_RD-1:0][IDX_W-1:0]     i_reg_rd,
  output logic [NUM_RD-1:0][SLICE_W-1:0]   o_reg_rd_data,
  input  logic [IDX_W-1:0]                 i_reg_wr,
  input  logic                             i_reg_wr_en,
  input  logic [SLICE_W-1:0]               i_reg_wr_data,
  output logic [PH_W-1:0]                  o_reg_phase,
  output logic                             o_reg_sof,
  output logic                             o_reg_wr_busy,
  output logic                             o_reg_wr_rej
);
  typedef enum logic {S_IDLE, S_WRITE} state_t;

  state_t                          r_state, w_state_nxt;
  logic [PH_W-1:0]                 r_phase;
  logic [IDX_W-1:0]                r_wr_idx;
  logic [REG_W-1:0]                r_regs [NUM_REGS];
  logic [NUM_REGS-1:0][SLICE_W-1:0] w_ls;

  logic             w_act, w_last, w_start, w_wr_ok, w_ins;
  logic [IDX_W-1:0] w_wr_idx;

  assign w_act   = ~i_reg_stall;
  assign w_last  = (r_phase == PH_W'(SLICES-1));
  assign w_start = w_act & i_reg_wr_en & (r_state == S_IDLE) & (r_phase == '0);

  // The start cycle writes slice 0 before the index is latched, so use the live index then.
  assign w_wr_idx = (r_state == S_IDLE) ? i_reg_wr : r_wr_idx;
  assign w_wr_ok  = (32'(w_wr_idx) < 32'(NUM_REGS)) && !(ZERO_R0 && (w_wr_idx == '0));
  assign w_ins    = (w_start | ((r_state == S_WRITE) & w_act)) & w_wr_ok;

  assign o_reg_phase = r_phase;
  assign o_reg_sof   = (r_phase == '0);

  always_ff @(posedge i_reg_gck or posedge i_reg_rst) begin
    if (i_reg_rst) begin
      r_state  <= S_IDLE;
      r_phase  <= '0;
      r_wr_idx <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_act) r_phase <= w_last ? '0 : r_phase + 1'b1;
      if (w_start) r_wr_idx <= i_reg_wr;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    o_reg_wr_busy = 1'b0;
    o_reg_wr_rej  = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_reg_wr_busy = w_start;
        o_reg_wr_rej  = w_act & i_reg_wr_en & (r_phase != '0);
        if (w_start) w_state_nxt = S_WRITE;
      end
      S_WRITE: begin
        o_reg_wr_busy = 1'b1;
        if (w_act && w_last) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Inserting the new slice at the top keeps the old slices flowing out of the
  // LS end, so readers see the old value for the whole write frame.
  always_ff @(posedge i_reg_gck or posedge i_reg_rst) begin
    if (i_reg_rst) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else if (w_act) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (w_ins && (w_wr_idx == IDX_W'(i)))
          r_regs[i] <= {i_reg_wr_data, r_regs[i][REG_W-1:SLICE_W]};
        else
          r_regs[i] <= {r_regs[i][SLICE_W-1:0], r_regs[i][REG_W-1:SLICE_W]};
      end
    end
  end

  always_comb begin
    w_ls = '0;
    for (int i = 0; i < NUM_REGS; i++) w_ls[i] = r_regs[i][SLICE_W-1:0];
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    idli_sregs_rd_m #(
      .NUM_REGS(NUM_REGS), .IDX_W(IDX_W), .SLICE_W(SLICE_W), .ZERO_R0(ZERO_R0)
    ) u_rd (
      .i_ls   (w_ls),
      .i_idx  (i_reg_rd[p]),
      .o_data (o_reg_rd_data[p])
    );
  end
endmodule

// File: tb/tb_idli_sregs_m.sv
// Scoreboard bench for idli_sregs_m: a word-level model predicts every cycle's
// outputs; a second instance covers ZERO_R0 and a non-power-of-two register count.

module tb_idli_sregs_m;
  localparam int NR = 8, SL = 4, IW = 3;

  logic gclk = 1'b0;
  logic rst  = 1'b1;
  always #5 gclk = ~gclk;

  logic               stall, wr_en, z_wr_en;
  logic [IW-1:0]      wr, z_wr;
  logic [3:0]         wdat, z_wdat;
  logic [1:0][IW-1:0] rd, z_rd;
  logic [1:0][3:0]    rd_data, z_rd_data;
  logic [1:0]         phase, z_phase;
  logic               sof, busy, rej, z_sof, z_busy, z_rej;

  idli_sregs_m dut (
    .i_reg_gck(gclk), .i_reg_rst(rst), .i_reg_stall(stall),
    .i_reg_rd(rd), .o_reg_rd_data(rd_data),
    .i_reg_wr(wr), .i_reg_wr_en(wr_en), .i_reg_wr_data(wdat),
    .o_reg_phase(phase), .o_reg_sof(sof), .o_reg_wr_busy(busy), .o_reg_wr_rej(rej)
  );

  idli_sregs_m #(.NUM_REGS(6), .ZERO_R0(1'b1)) dut_z (
    .i_reg_gck(gclk), .i_reg_rst(rst), .i_reg_stall(1'b0),
    .i_reg_rd(z_rd), .o_reg_rd_data(z_rd_data),
    .i_reg_wr(z_wr), .i_reg_wr_en(z_wr_en), .i_reg_wr_data(z_wdat),
    .o_reg_phase(z_phase), .o_reg_sof(z_sof), .o_reg_wr_busy(z_busy), .o_reg_wr_rej(z_rej)
  );

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  localparam int K_RD0 = 0, K_RD1 = 1, K_PH = 2, K_SOF = 3, K_BUSY = 4, K_REJ = 5,
                 K_ZRD0 = 6, K_ZRD1 = 7, K_ZBUSY = 8, K_ZREJ = 9;

  typedef struct { int kind; logic [15:0] exp; string tag; } sb_t;
  sb_t sbq[$];

  function automatic void push(input int k, input logic [15:0] e, input string t);
    sb_t x;
    x.kind = k; x.exp = e; x.tag = t;
    sbq.push_back(x);
  endfunction

  function automatic logic [15:0] observe(input int k);
    case (k)
      K_RD0:   return 16'(rd_data[0]);
      K_RD1:   return 16'(rd_data[1]);
      K_PH:    return 16'(phase);
      K_SOF:   return 16'(sof);
      K_BUSY:  return 16'(busy);
      K_REJ:   return 16'(rej);
      K_ZRD0:  return 16'(z_rd_data[0]);
      K_ZRD1:  return 16'(z_rd_data[1]);
      K_ZBUSY: return 16'(z_busy);
      default: return 16'(z_rej);
    endcase
  endfunction

  // Word-level model: a write commits its assembled word at the end of its frame.
  logic [15:0] m_regs [NR];
  logic [15:0] m_acc;
  int          m_ph, m_idx;
  bit          m_wr;

  function automatic void m_reset();
    for (int i = 0; i < NR; i++) m_regs[i] = '0;
    m_ph = 0; m_wr = 0; m_idx = 0; m_acc = '0;
  endfunction

  function automatic logic [3:0] m_slice(input int idx);
    return (idx >= NR) ? 4'h0 : m_regs[idx][m_ph*4 +: 4];
  endfunction

  function automatic void push_main();
    bit start = !stall && wr_en && !m_wr && (m_ph == 0);
    push(K_PH,   16'(m_ph), "phase");
    push(K_SOF,  16'(m_ph == 0), "sof");
    push(K_BUSY, 16'(m_wr || start), "busy");
    push(K_REJ,  16'(!m_wr && !stall && wr_en && (m_ph != 0)), "rej");
    push(K_RD0,  16'(m_slice(int'(rd[0]))), "rd0");
    push(K_RD1,  16'(m_slice(int'(rd[1]))), "rd1");
  endfunction

  function automatic void m_update();
    if (!stall) begin
      if (!m_wr && wr_en && (m_ph == 0)) begin m_wr = 1; m_idx = int'(wr); end
      if (m_wr) begin
        m_acc[m_ph*4 +: 4] = wdat;
        if (m_ph == SL-1) begin
          m_regs[m_idx] = m_acc;
          m_wr = 0;
        end
      end
      m_ph = (m_ph + 1) % SL;
    end
  endfunction

  // Called just after a negedge with inputs driven: predict, sample, then advance.
  task automatic cyc();
    sb_t x;
    push_main();
    #2;
    while (sbq.size() > 0) begin
      x = sbq.pop_front();
      chk(x.tag, observe(x.kind), x.exp);
    end
    @(posedge gclk);
    m_update();
    @(negedge gclk);
  endtask

  task automatic write_word(input logic [IW-1:0] idx, input logic [15:0] v);
    for (int s = 0; s < SL; s++) begin
      wr_en = 1'b1; wr = idx; wdat = v[s*4 +: 4];
      cyc();
    end
    wr_en = 1'b0;
  endtask

  task automatic read_word(input logic [IW-1:0] idx, output logic [15:0] v);
    v = '0;
    for (int s = 0; s < SL; s++) begin
      rd = {idx, idx};
      #1 v[s*4 +: 4] = rd_data[0];
      cyc();
    end
  endtask

  logic [15:0] got;

  initial begin
    stall = 0; wr_en = 0; wr = '0; wdat = '0; rd = '0;
    z_wr_en = 0; z_wr = '0; z_wdat = '0; z_rd = '0;
    m_reset();
    repeat (2) @(negedge gclk);
    rst = 1'b0;

    // Idle frames: everything reads zero, phase/sof cycle.
    for (int i = 0; i < 32; i++) begin
      rd = {IW'((i + 3) % NR), IW'(i % NR)};
      cyc();
    end

    // Write 0xBEEF (slices F,E,E,B) to r3; old value visible during the frame.
    rd = {IW'(3), IW'(3)};
    write_word(3'd3, 16'hBEEF);
    read_word(3'd3, got);
    chk("r3_word", got, 16'hBEEF);

    // Request at phase 2 is rejected.
    cyc(); cyc();
    wr_en = 1'b1; wr = 3'd4; wdat = 4'h9;
    cyc();
    wr_en = 1'b0;
    cyc();
    read_word(3'd4, got);
    chk("r4_after_rej", got, 16'h0000);

    // r5 <= 0x1234 with a 3-cycle stall after slice 0; wr_en noise ignored.
    wr_en = 1'b1; wr = 3'd5; wdat = 4'h4;
    cyc();
    stall = 1'b1; wr = 3'd6; wdat = 4'hF;
    repeat (3) cyc();
    stall = 1'b0; wr = 3'd6;
    for (int s = 1; s < SL; s++) begin
      wdat = 4'(4 - s);
      cyc();
    end
    wr_en = 1'b0;
    read_word(3'd5, got);
    chk("r5_word", got, 16'h1234);
    read_word(3'd6, got);
    chk("r6_untouched", got, 16'h0000);
    read_word(3'd3, got);
    chk("r3_kept", got, 16'hBEEF);

    // Back-to-back writes.
    write_word(3'd1, 16'hA5C3);
    write_word(3'd7, 16'h0F0F);
    read_word(3'd1, got);
    chk("r1_word", got, 16'hA5C3);
    read_word(3'd7, got);
    chk("r7_word", got, 16'h0F0F);

    // Reset after two slices of a 0xFFFF write to r2.
    wr_en = 1'b1; wr = 3'd2; wdat = 4'hF;
    cyc(); cyc();
    wr_en = 1'b0; rd = {IW'(2), IW'(3)};
    rst = 1'b1;
    #1;
    chk("rst_busy", 16'(busy), 16'h0);
    chk("rst_phase", 16'(phase), 16'h0);
    chk("rst_rd_r2", 16'(rd_data[0]), 16'h0);
    chk("rst_rd_r3", 16'(rd_data[1]), 16'h0);
    m_reset();
    @(negedge gclk);
    rst = 1'b0;
    read_word(3'd2, got);
    chk("r2_after_rst", got, 16'h0000);

    // ZERO_R0 / NUM_REGS=6 instance, phase-aligned with the main one since reset.
    for (int s = 0; s < SL; s++) begin
      z_wr_en = 1'b1; z_wr = 3'd0; z_wdat = 4'(16'hABCD >> (s*4));
      z_rd = {IW'(7), IW'(0)};
      push(K_ZBUSY, 16'h1, "z_busy_r0");
      push(K_ZRD0, 16'h0, "z_rd_r0_wr");
      cyc();
    end
    z_wr_en = 1'b0;
    for (int s = 0; s < SL; s++) begin
      push(K_ZBUSY, 16'h0, "z_idle");
      push(K_ZRD0, 16'h0, "z_rd_r0");
      push(K_ZRD1, 16'h0, "z_rd_idx7");
      cyc();
    end
    for (int s = 0; s < SL; s++) begin
      z_wr_en = 1'b1; z_wr = 3'd1; z_wdat = 4'(16'h5A3C >> (s*4));
      push(K_ZREJ, 16'h0, "z_rej");
      cyc();
    end
    for (int s = 0; s < SL; s++) begin
      z_wr_en = (s == 0); z_wr = 3'd7; z_wdat = 4'hF;
      z_rd = {IW'(7), IW'(1)};
      push(K_ZBUSY, 16'h1, "z_busy_idx7");
      push(K_ZRD0, 16'(16'h5A3C >> (s*4)) & 16'hF, "z_rd_r1");
      cyc();
    end
    z_wr_en = 1'b0;
    for (int s = 0; s < SL; s++) begin
      push(K_ZRD0, 16'(16'h5A3C >> (s*4)) & 16'hF, "z_rd_r1_after");
      push(K_ZRD1, 16'h0, "z_rd_idx7_after");
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
